// File: rtl/req_gbf_mc.sv
// Multi-channel GBF request generator: per-bank epoch counters, fill level, watermark FSMs, round-robin request port.
// Optional build macro REQ_GBF_MC_ERR_EN adds the sticky per-channel overflow/underflow flag Err.
module req_gbf_mc #(
    parameter int NUM_CH    = 4,
    parameter int DEPTH     = 128,
    parameter int CNT_WIDTH = 4,
    parameter int AW        = $clog2(DEPTH),
    parameter int LW        = AW + 1,
    parameter int CW        = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Reset,
    input  logic [NUM_CH-1:0]    EnWr,
    input  logic [NUM_CH*AW-1:0] AddrWr,
    input  logic [NUM_CH-1:0]    EnRd,
    input  logic [NUM_CH*AW-1:0] AddrRd,
    input  logic [NUM_CH-1:0]    CfgMode,
    input  logic [LW-1:0]        CfgLow,
    input  logic [LW-1:0]        CfgHigh,
    output logic                 ReqVld,
    output logic [CW-1:0]        ReqCh,
    input  logic                 Ack,
    output logic [NUM_CH*LW-1:0] Level
`ifdef REQ_GBF_MC_ERR_EN
    ,
    output logic [NUM_CH-1:0]    Err
`endif
);

    localparam int PW = CNT_WIDTH + AW;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_PEND,
        CH_SERV
    } ch_state_t;

    logic [CNT_WIDTH-1:0] cnt_wr [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_rd [NUM_CH];
    ch_state_t            state  [NUM_CH];
    logic [CW-1:0]        last_grant;

    logic [PW-1:0]        wr_ptr [NUM_CH];
    logic [PW-1:0]        rd_ptr [NUM_CH];
    logic [LW-1:0]        lvl    [NUM_CH];
    logic [NUM_CH-1:0]    wr_wrap, rd_wrap, trig, rel, pend;
    logic                 hs, can_issue, sel_vld;
    logic [CW-1:0]        sel_ch;

    // Epoch-extended pointers make the subtraction immune to both address and epoch wrap.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr[i]  = {cnt_wr[i], AddrWr[i*AW +: AW]};
            rd_ptr[i]  = {cnt_rd[i], AddrRd[i*AW +: AW]};
            lvl[i]     = LW'(wr_ptr[i] - rd_ptr[i]);
            wr_wrap[i] = EnWr[i] && (AddrWr[i*AW +: AW] == AW'(DEPTH - 1));
            rd_wrap[i] = EnRd[i] && (AddrRd[i*AW +: AW] == AW'(DEPTH - 1));
            trig[i]    = CfgMode[i] ? (lvl[i] <= CfgLow)  : (lvl[i] >= CfgHigh);
            rel[i]     = CfgMode[i] ? (lvl[i] >= CfgHigh) : (lvl[i] <= CfgLow);
        end
    end

    assign hs        = ReqVld && Ack;
    assign can_issue = !ReqVld || hs;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        int idx;
        idx     = 0;
        sel_vld = 1'b0;
        sel_ch  = '0;
        for (int i = 0; i < NUM_CH; i++)
            pend[i] = (state[i] == CH_PEND) && !(hs && (ReqCh == CW'(i)));
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_grant) + k) % NUM_CH;
            if (!sel_vld && pend[CW'(idx)]) begin
                sel_vld = 1'b1;
                sel_ch  = CW'(idx);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_wr[i] <= '0;
                cnt_rd[i] <= '0;
                state[i]  <= CH_IDLE;
            end
            Level <= '0;
        end else if (Reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_wr[i] <= '0;
                cnt_rd[i] <= '0;
                state[i]  <= CH_IDLE;
            end
            Level <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_wrap[i]) cnt_wr[i] <= cnt_wr[i] + CNT_WIDTH'(1);
                if (rd_wrap[i]) cnt_rd[i] <= cnt_rd[i] + CNT_WIDTH'(1);
                Level[i*LW +: LW] <= lvl[i];
                case (state[i])
                    CH_IDLE: if (trig[i]) state[i] <= CH_PEND;
                    CH_PEND: if (hs && (ReqCh == CW'(i))) state[i] <= CH_SERV;
                    CH_SERV: if (rel[i]) state[i] <= CH_IDLE;
                    default: state[i] <= CH_IDLE;
                endcase
            end
        end
    end

    // Request stays frozen until accepted; a new pick happens only when the port is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReqVld     <= 1'b0;
            ReqCh      <= '0;
            last_grant <= CW'(NUM_CH - 1);
        end else if (Reset) begin
            ReqVld     <= 1'b0;
            ReqCh      <= '0;
            last_grant <= CW'(NUM_CH - 1);
        end else if (can_issue) begin
            ReqVld <= sel_vld;
            if (sel_vld) begin
                ReqCh      <= sel_ch;
                last_grant <= sel_ch;
            end
        end
    end

`ifdef REQ_GBF_MC_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Err <= '0;
        end else if (Reset) begin
            Err <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if ((EnWr[i] && (lvl[i] == LW'(DEPTH))) || (EnRd[i] && (lvl[i] == '0)))
                    Err[i] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_req_gbf_mc.sv
// Self-checking bench for req_gbf_mc: pointer model for levels, queue of expected grant channels.
module tb_req_gbf_mc;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 128;
    localparam int AW     = 7;
    localparam int LW     = 8;
    localparam int CW     = 2;

    logic                 clk = 1'b0;
    logic                 rst_n, Reset, Ack;
    logic [NUM_CH-1:0]    EnWr, EnRd, CfgMode;
    logic [NUM_CH*AW-1:0] AddrWr, AddrRd;
    logic [LW-1:0]        CfgLow, CfgHigh;
    logic                 ReqVld;
    logic [CW-1:0]        ReqCh;
    logic [NUM_CH*LW-1:0] Level;
`ifdef REQ_GBF_MC_ERR_EN
    logic [NUM_CH-1:0]    Err;
`endif

    int wr_ptr [NUM_CH];
    int rd_ptr [NUM_CH];
    int exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;
    logic seen;

    req_gbf_mc #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .Reset(Reset),
        .EnWr(EnWr), .AddrWr(AddrWr), .EnRd(EnRd), .AddrRd(AddrRd),
        .CfgMode(CfgMode), .CfgLow(CfgLow), .CfgHigh(CfgHigh),
        .ReqVld(ReqVld), .ReqCh(ReqCh), .Ack(Ack), .Level(Level)
`ifdef REQ_GBF_MC_ERR_EN
        , .Err(Err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lvl_of(input int c);
        return int'(Level[c*LW +: LW]);
    endfunction

    function automatic int exp_lvl(input int c);
        return (wr_ptr[c] - rd_ptr[c]) & 255;
    endfunction

    task automatic drive_addrs();
        for (int c = 0; c < NUM_CH; c++) begin
            AddrWr[c*AW +: AW] = AW'(wr_ptr[c] % DEPTH);
            AddrRd[c*AW +: AW] = AW'(rd_ptr[c] % DEPTH);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [NUM_CH-1:0] wm, input logic [NUM_CH-1:0] rm);
        EnWr = wm;
        EnRd = rm;
        tick();
        for (int c = 0; c < NUM_CH; c++) begin
            if (wm[c]) wr_ptr[c]++;
            if (rm[c]) rd_ptr[c]++;
        end
        EnWr = '0;
        EnRd = '0;
        drive_addrs();
    endtask

    task automatic burst(input logic [NUM_CH-1:0] wm, input logic [NUM_CH-1:0] rm, input int n);
        for (int k = 0; k < n; k++) begin
            strobe(wm, rm);
            if (ReqVld) seen = 1'b1;
        end
    endtask

    task automatic wait_vld(input string tag, input int budget);
        for (int k = 0; k < budget && !ReqVld; k++) tick();
        check({"vld_", tag}, ReqVld, 1);
    endtask

    task automatic serve(input string tag, input int ch);
        exp_q.push_back(ch);
        wait_vld(tag, 10);
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
    endtask

    task automatic pulse_reset(input bit keep_addr);
        Reset = 1'b1;
        if (!keep_addr) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] = 0;
                rd_ptr[c] = 0;
            end
            drive_addrs();
        end
        tick();
        Reset = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr[c] = wr_ptr[c] % DEPTH;
            rd_ptr[c] = rd_ptr[c] % DEPTH;
        end
    endtask

    // Every accepted request must match the oldest expected channel.
    always @(negedge clk) begin
        if (rst_n && !Reset && ReqVld === 1'b1 && Ack === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_grant", ReqCh, 32'hFFFF_FFFF);
            else check("req_ch", ReqCh, exp_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        rst_n = 1'b0; Reset = 1'b0; Ack = 1'b0;
        EnWr = '0; EnRd = '0; CfgMode = '0; CfgLow = 8'd16; CfgHigh = 8'd64;
        for (int c = 0; c < NUM_CH; c++) begin wr_ptr[c] = 0; rd_ptr[c] = 0; end
        drive_addrs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_vld", ReqVld, 0);
        check("rst_ch", ReqCh, 0);
        check("rst_level", Level, 0);
        seen = 1'b0;
        Ack = 1'b1;
        for (int k = 0; k < 20; k++) begin tick(); if (ReqVld) seen = 1'b1; end
        Ack = 1'b0;
        check("idle_no_req", seen, 0);

        // Drain trigger on ch1 with exact latencies
        burst(4'b0010, 4'b0000, 64);
        check("lvl1_comb_lag", lvl_of(1), 63);
        tick();
        check("lvl1_64", lvl_of(1), 64);
        check("drain_vld_t1", ReqVld, 0);
        tick();
        check("drain_vld_t2", ReqVld, 1);
        check("drain_ch_t2", ReqCh, 1);
        exp_q.push_back(1);
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        check("drain_ack_clr", ReqVld, 0);
        seen = 1'b0;
        burst(4'b0000, 4'b0010, 48);
        check("drain_no_rereq", seen, 0);
        tick();
        check("lvl1_16", lvl_of(1), exp_lvl(1));
        burst(4'b0010, 4'b0000, 48);
        serve("drain2", 1);

        // Fill mode with hysteresis on ch0
        CfgMode = 4'b0001;
        serve("fill1", 0);
        seen = 1'b0;
        burst(4'b0001, 4'b0000, 40);
        tick();
        check("fill_hyst_40", seen, 0);
        check("lvl0_40", lvl_of(0), 40);
        burst(4'b0001, 4'b0000, 24);
        tick();
        seen = 1'b0;
        burst(4'b0000, 4'b0001, 48);
        check("fill_no_early", seen, 0);
        serve("fill2", 0);

        // Round-robin, back-to-back with Ack held high
        CfgMode = '0;
        pulse_reset(0);
        exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(3);
        Ack = 1'b1;
        CfgMode = 4'b1101;
        wait_vld("rr1", 5);
        for (int k = 0; k < 3; k++) begin
            check("rr1_no_bubble", ReqVld, 1);
            tick();
        end
        Ack = 1'b0;
        check("rr1_done", ReqVld, 0);
        strobe(4'b1101, 4'b0000);
        CfgLow = 8'd0; CfgHigh = 8'd1;
        tick();
        strobe(4'b0000, 4'b0100);
        serve("rr_g2", 2);
        strobe(4'b0100, 4'b0000);
        tick();
        exp_q.push_back(0); exp_q.push_back(2);
        Ack = 1'b1;
        strobe(4'b0000, 4'b0101);
        wait_vld("rr2", 5);
        for (int k = 0; k < 2; k++) begin
            check("rr2_no_bubble", ReqVld, 1);
            tick();
        end
        Ack = 1'b0;
        check("rr2_done", ReqVld, 0);

        // Address and epoch wrap on ch2, with same-cycle wr/rd
        CfgMode = '0; CfgLow = 8'd16; CfgHigh = 8'd64;
        pulse_reset(0);
        burst(4'b0100, 4'b0000, 40);
        for (int k = 0; k < 260; k++) begin
            if (k % 2 == 0) strobe(4'b0100, 4'b0100);
            else begin strobe(4'b0100, 4'b0000); strobe(4'b0000, 4'b0100); end
            if (k % 52 == 51) begin tick(); check("wrap_lvl", lvl_of(2), 40); end
        end
        for (int k = 0; k < 1800; k++) begin
            strobe(4'b0100, 4'b0100);
            if (k % 450 == 449) begin tick(); check("epoch_lvl", lvl_of(2), 40); end
        end
        tick();
        check("wrap_model", exp_lvl(2), 40);
        check("wrap_final", lvl_of(2), exp_lvl(2));
        check("wrap_no_req", ReqVld, 0);

        // Mid-operation reset with an un-acked request outstanding
        pulse_reset(0);
        burst(4'b1000, 4'b0000, 128);
        check("hold_vld", ReqVld, 1);
        check("hold_ch", ReqCh, 3);
        tick();
        check("hold_ch2", ReqCh, 3);
`ifdef REQ_GBF_MC_ERR_EN
        check("err_clear", Err[3], 0);
        strobe(4'b1000, 4'b0000);
        check("err_set", Err[3], 1);
        tick();
        check("err_sticky", Err[3], 1);
`endif
        pulse_reset(1);
        check("mid_rst_vld", ReqVld, 0);
        check("mid_rst_level", lvl_of(3), 0);
`ifdef REQ_GBF_MC_ERR_EN
        check("err_rst", Err[3], 0);
`endif
        tick();
        check("mid_rst_cnt", lvl_of(3), exp_lvl(3));
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin tick(); if (ReqVld) seen = 1'b1; end
        check("mid_rst_no_req", seen, 0);

        check("q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
